// File: rtl/sample_run_ctrl.sv
// Run sequencer for the sample edge-detect datapath: arms the detector, waits for
// the address window, collects falling-edge samples and guards the run with a watchdog.
module sample_run_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8,
  parameter int TMO_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic [DATA_WIDTH-1:0] delay_cfg,
  input  logic [TMO_W-1:0]      timeout_cfg,
  input  logic                  det_stop,
  input  logic                  det_addr_en,
  output logic                  det_resetb,
  output logic [DATA_WIDTH-1:0] det_delay,
  output logic                  cal_done,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [CNT_W-1:0]      sample_idx,
  output logic                  done,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_ADDR,
    S_RUN,
    S_CAL,
    S_FINISH
  } state_t;

  state_t           state, next_state;
  logic             arm_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [TMO_W-1:0] tmo_lat;
  logic [TMO_W-1:0] wd_cnt;
  logic             start_acc;
  logic             accept;
  logic             tmo_hit;
  logic             wd_active;
  logic             wd_expired;

  assign wd_active  = (state == S_WAIT_ADDR) || (state == S_RUN);
  assign wd_expired = wd_active && (tmo_lat != '0) && (wd_cnt == tmo_lat);

  // Priority inside each active state: abort, then watchdog, then detector events.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    next_state = state;
    start_acc  = 1'b0;
    accept     = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          next_state = S_ARM;
        end
      end
      S_ARM: begin
        // The zero-count decision uses the latched count, so it is taken here.
        if (abort)                next_state = S_IDLE;
        else if (num_lat == '0)   next_state = S_FINISH;
        else if (arm_cnt)         next_state = S_WAIT_ADDR;
      end
      S_WAIT_ADDR: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (wd_expired) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end else if (det_addr_en) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (wd_expired) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end else if (det_stop) begin
          accept     = 1'b1;
          next_state = S_CAL;
        end
      end
      S_CAL: begin
        if (abort)                      next_state = S_IDLE;
        else if (sample_idx == num_lat) next_state = S_FINISH;
        else                            next_state = S_RUN;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= S_IDLE;
      arm_cnt      <= 1'b0;
      num_lat      <= '0;
      tmo_lat      <= '0;
      wd_cnt       <= '0;
      det_delay    <= '0;
      det_resetb   <= 1'b0;
      cal_done     <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= next_state;
      arm_cnt <= (state == S_ARM) && !arm_cnt;

      if (start_acc) begin
        num_lat     <= num_samples;
        tmo_lat     <= timeout_cfg;
        det_delay   <= delay_cfg;
        sample_idx  <= '0;
        timeout_err <= 1'b0;
      end

      if (tmo_hit) timeout_err <= 1'b1;

      // Saturating index: a full-scale count ends at the maximum instead of wrapping.
      if (accept && (sample_idx != {CNT_W{1'b1}})) sample_idx <= sample_idx + 1'b1;

      if (((next_state == S_WAIT_ADDR) && (state != S_WAIT_ADDR)) || accept)
        wd_cnt <= '0;
      else if (wd_active && (wd_cnt != {TMO_W{1'b1}}))
        wd_cnt <= wd_cnt + 1'b1;

      // Outputs are registered from the next state so they align with it.
      busy         <= (next_state != S_IDLE);
      det_resetb   <= (next_state == S_WAIT_ADDR) || (next_state == S_RUN) ||
                      (next_state == S_CAL);
      cal_done     <= (next_state == S_CAL);
      done         <= (next_state == S_FINISH);
      sample_valid <= accept;
    end
  end

endmodule
